// File: rtl/mem_sequencer_if.sv
// Request and SRAM pad bundle for mem_sequencer.
// The slave modport is the sequencer; the master modport is the control unit / pad side.
interface mem_sequencer_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              Req;
  logic              We;
  logic [ADDR_W-1:0] Addr;
  logic [15:0]       Wdata;
  logic [1:0]        Byte_sel;
  logic [15:0]       Rdata;
  logic              Ready;
  logic              Busy;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              CE_N;
  logic              OE_N;
  logic              WE_N;
  logic              UB_N;
  logic              LB_N;
  logic [15:0]       Data_out;
  logic              Data_oe;
  logic [15:0]       Data_in;

  modport slave (
    input  Req, We, Addr, Wdata, Byte_sel, Data_in,
    output Rdata, Ready, Busy, SRAM_ADDR, CE_N, OE_N, WE_N, UB_N, LB_N, Data_out, Data_oe
  );

  modport master (
    output Req, We, Addr, Wdata, Byte_sel, Data_in,
    input  Rdata, Ready, Busy, SRAM_ADDR, CE_N, OE_N, WE_N, UB_N, LB_N, Data_out, Data_oe
  );
endinterface

// File: rtl/mem_sequencer.sv
// Multi-cycle asynchronous SRAM access sequencer (SETUP / ACCESS / HOLD / DONE).
// Optional byte-lane strobes enabled by defining MEM_SEQ_BYTE_EN.
module mem_sequencer #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic             Clk,
  input logic             Reset,
  mem_sequencer_if.slave  bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                ub_n_q, ub_n_d;
  logic                lb_n_q, lb_n_d;
  logic                data_oe_q, data_oe_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                active_d;
`ifdef MEM_SEQ_BYTE_EN
  logic [1:0]          byte_sel_q, byte_sel_d;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MEM_SEQ_BYTE_EN
      byte_sel_q <= 2'b00;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      ub_n_q    <= ub_n_d;
      lb_n_q    <= lb_n_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef MEM_SEQ_BYTE_EN
      byte_sel_q <= byte_sel_d;
`endif
    end
  end

  // Next state, request latching and read capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_SEQ_BYTE_EN
    byte_sel_d = byte_sel_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Req) begin
          addr_d  = bus.Addr;
          we_d    = bus.We;
          wdata_d = bus.Wdata;
`ifdef MEM_SEQ_BYTE_EN
          byte_sel_d = bus.Byte_sel;
`endif
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          if (!we_q) rdata_d = bus.Data_in;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decoded from the next state so the registered outputs line up with the state.
  always_comb begin
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    data_oe_d = 1'b0;
    ready_d   = 1'b0;
    busy_d    = (state_d != IDLE);
    active_d  = 1'b0;
    case (state_d)
      SETUP: begin
        ce_n_d    = 1'b0;
        data_oe_d = we_d;
        active_d  = 1'b1;
      end
      ACCESS: begin
        ce_n_d   = 1'b0;
        active_d = 1'b1;
        if (we_d) begin
          we_n_d    = 1'b0;
          data_oe_d = 1'b1;
        end else begin
          oe_n_d = 1'b0;
        end
      end
      HOLD: begin
        ce_n_d    = 1'b0;
        data_oe_d = we_d;
        active_d  = 1'b1;
      end
      DONE:    ready_d = 1'b1;
      default: ;
    endcase
`ifdef MEM_SEQ_BYTE_EN
    ub_n_d = active_d ? ~byte_sel_d[1] : 1'b1;
    lb_n_d = active_d ? ~byte_sel_d[0] : 1'b1;
`else
    ub_n_d = ~active_d;
    lb_n_d = ~active_d;
`endif
  end

  assign bus.Rdata     = rdata_q;
  assign bus.Ready     = ready_q;
  assign bus.Busy      = busy_q;
  assign bus.SRAM_ADDR = addr_q;
  assign bus.CE_N      = ce_n_q;
  assign bus.OE_N      = oe_n_q;
  assign bus.WE_N      = we_n_q;
  assign bus.UB_N      = ub_n_q;
  assign bus.LB_N      = lb_n_q;
  assign bus.Data_out  = wdata_q;
  assign bus.Data_oe   = data_oe_q;
endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a 64-word behavioural SRAM model.
module tb_mem_sequencer;
  localparam int unsigned ADDR_W = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [15:0] mem [64];
  logic        pl_en;
  logic [5:0]  pl_addr;
  logic [15:0] pl_data;

  mem_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  mem_sequencer #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: asynchronous read, write while CE_N and WE_N are both low.
  assign bus.Data_in = mem[bus.SRAM_ADDR[5:0]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!bus.CE_N && !bus.WE_N) mem[bus.SRAM_ADDR[5:0]] <= bus.Data_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.Req = 1'b1; bus.We = 1'b0; bus.Addr = 20'h0001A;
    tick(); tick();
    checks++;
    if ({bus.CE_N, bus.OE_N, bus.WE_N, bus.UB_N, bus.LB_N} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 11111", {bus.CE_N, bus.OE_N, bus.WE_N, bus.UB_N, bus.LB_N});
    end
    checks++;
    if ({bus.Ready, bus.Busy, bus.Data_oe} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready_busy_oe got %b exp 000", {bus.Ready, bus.Busy, bus.Data_oe});
    end
    checks++;
    if (bus.Rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rdata got %h exp 0000", bus.Rdata);
    end
    bus.Req = 1'b0; rst_n = 1'b1;
    tick();
    checks++;
    if (bus.Busy !== 1'b0 || bus.CE_N !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_access got busy=%b ce_n=%b exp busy=0 ce_n=1", bus.Busy, bus.CE_N);
    end
  endtask

  task automatic test_read();
    bus.Req = 1'b1; bus.We = 1'b0; bus.Addr = 20'h0001A;
    tick();
    bus.Req = 1'b0; bus.Addr = 20'h0003F;
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (bus.OE_N !== ((c == 2 || c == 3) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL read_oe_n cycle %0d got %b exp %b", c, bus.OE_N, (c == 2 || c == 3) ? 1'b0 : 1'b1);
      end
      checks++;
      if (bus.Ready !== (c == 5)) begin
        errors++;
        $display("FAIL read_ready cycle %0d got %b exp %b", c, bus.Ready, (c == 5));
      end
      if (c == 3) begin
        checks++;
        if (bus.SRAM_ADDR !== 20'h0001A) begin
          errors++;
          $display("FAIL read_addr_held got %h exp 0001a", bus.SRAM_ADDR);
        end
      end
      if (c == 4 || c == 5) begin
        checks++;
        if (bus.Rdata !== 16'hBEEF) begin
          errors++;
          $display("FAIL read_rdata cycle %0d got %h exp beef", c, bus.Rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_write();
    bus.Req = 1'b1; bus.We = 1'b1; bus.Addr = 20'h00030; bus.Wdata = 16'h1234;
    tick();
    bus.Req = 1'b0; bus.Wdata = 16'hFFFF;
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (bus.WE_N !== ((c == 2 || c == 3) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL write_we_n cycle %0d got %b exp %b", c, bus.WE_N, (c == 2 || c == 3) ? 1'b0 : 1'b1);
      end
      checks++;
      if (bus.Data_oe !== (c >= 1 && c <= 4)) begin
        errors++;
        $display("FAIL write_data_oe cycle %0d got %b exp %b", c, bus.Data_oe, (c >= 1 && c <= 4));
      end
      checks++;
      if (bus.Ready !== (c == 5)) begin
        errors++;
        $display("FAIL write_ready cycle %0d got %b exp %b", c, bus.Ready, (c == 5));
      end
      tick();
    end
    checks++;
    if (mem[6'h30] !== 16'h1234) begin
      errors++;
      $display("FAIL write_mem got %h exp 1234", mem[6'h30]);
    end
    checks++;
    if (bus.Data_out !== 16'h1234) begin
      errors++;
      $display("FAIL write_data_out got %h exp 1234", bus.Data_out);
    end
  endtask

  task automatic test_back_to_back();
    bus.Req = 1'b1; bus.We = 1'b0; bus.Addr = 20'h00005;
    tick();
    bus.Addr = 20'h00006;
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (bus.Busy !== (c != 6 && c != 12)) begin
        errors++;
        $display("FAIL b2b_busy cycle %0d got %b exp %b", c, bus.Busy, (c != 6 && c != 12));
      end
      if (c == 5) begin
        checks++;
        if (bus.Rdata !== 16'h1111) begin
          errors++;
          $display("FAIL b2b_rdata_first got %h exp 1111", bus.Rdata);
        end
      end
      if (c == 11) begin
        checks++;
        if (bus.Ready !== 1'b1 || bus.Rdata !== 16'h2222) begin
          errors++;
          $display("FAIL b2b_rdata_second got ready=%b rdata=%h exp ready=1 rdata=2222", bus.Ready, bus.Rdata);
        end
        bus.Req = 1'b0;
      end
      tick();
    end
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_repeat got busy=%b exp 0", bus.Busy);
    end
  endtask

  task automatic test_abort();
    int  ready_cnt;
    bit  found;
    ready_cnt = 0;
    found     = 1'b0;
    bus.Req = 1'b1; bus.We = 1'b1; bus.Addr = 20'h00020; bus.Wdata = 16'hAAAA;
    tick();
    bus.Req = 1'b0;
    tick();
    checks++;
    if (bus.WE_N !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_access got we_n=%b exp 0", bus.WE_N);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.WE_N, bus.CE_N, bus.Busy, bus.Data_oe, bus.Ready} !== 5'b11000) begin
      errors++;
      $display("FAIL abort_strobes got %b exp 11000", {bus.WE_N, bus.CE_N, bus.Busy, bus.Data_oe, bus.Ready});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (bus.Ready) ready_cnt++;
      tick();
    end
    checks++;
    if (ready_cnt !== 0) begin
      errors++;
      $display("FAIL abort_ready_pulses got %0d exp 0", ready_cnt);
    end
    bus.Req = 1'b1; bus.We = 1'b0; bus.Addr = 20'h00007;
    tick();
    bus.Req = 1'b0;
    checks++;
    if (bus.Busy !== 1'b1 || bus.CE_N !== 1'b0) begin
      errors++;
      $display("FAIL abort_new_req got busy=%b ce_n=%b exp busy=1 ce_n=0", bus.Busy, bus.CE_N);
    end
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.Ready) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found || bus.Rdata !== 16'h5A5A) begin
      errors++;
      $display("FAIL abort_new_read got found=%b rdata=%h exp found=1 rdata=5a5a", found, bus.Rdata);
    end
    tick();
  endtask

  task automatic test_byte_lanes();
    logic [1:0] exp_lanes;
`ifdef MEM_SEQ_BYTE_EN
    exp_lanes = 2'b10;
`else
    exp_lanes = 2'b00;
`endif
    bus.Req = 1'b1; bus.We = 1'b1; bus.Addr = 20'h00031; bus.Wdata = 16'h5678; bus.Byte_sel = 2'b01;
    tick();
    bus.Req = 1'b0; bus.Byte_sel = 2'b10;
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if ({bus.UB_N, bus.LB_N} !== ((c <= 4) ? exp_lanes : 2'b11)) begin
        errors++;
        $display("FAIL byte_lanes cycle %0d got %b exp %b", c, {bus.UB_N, bus.LB_N}, (c <= 4) ? exp_lanes : 2'b11);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.Req = 1'b0; bus.We = 1'b0; bus.Addr = '0; bus.Wdata = '0; bus.Byte_sel = 2'b00;
    preload(6'h1A, 16'hBEEF);
    preload(6'h05, 16'h1111);
    preload(6'h06, 16'h2222);
    preload(6'h07, 16'h5A5A);
    preload(6'h30, 16'h0000);
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_abort();
    test_byte_lanes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
